// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: length-prefixed big-endian words, CPU held in reset until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,S_CHECK = 3'd6
`endif
  } state_t;

  // Where the stream goes once the last word (or an empty image) has been handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CHECK;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t      state_q, state_d;
  logic [16:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [23:0] word_q, word_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        in_ready_q, in_ready_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept_s;
  logic [15:0] full_len_s;
  logic [16:0] idx_inc_s;

  assign accept_s   = in_valid && in_ready_q;
  assign full_len_s = {len_q[15:8], in_data};
  assign idx_inc_s  = idx_q + 17'd1;

  function automatic logic ready_of(input state_t s);
    logic r;
    case (s)
      S_LEN_HI, S_LEN_LO, S_DATA: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:                    r = 1'b1;
`endif
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    word_d      = word_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (accept_s) begin
      csum_d = csum_q ^ in_data;
    end else begin
      csum_d = csum_q;
    end
`endif
    case (state_q)
      S_LEN_HI: begin
        if (accept_s) begin
          len_d[15:8] = in_data;
          state_d     = S_LEN_LO;
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (accept_s) begin
          len_d = full_len_s;
          if (full_len_s == 16'd0) begin
            state_d = S_FINAL;
          end else if ({1'b0, full_len_s} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          word_d = {word_q[15:0], in_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {word_q, in_data};
            mem_addr_d  = BASE_ADDR + {13'd0, idx_q, 2'b00};
            state_d     = S_WRITE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        idx_d = idx_inc_s;
        if (idx_inc_s == {1'b0, len_q}) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept_s) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          state_d = S_CHECK;
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = 17'd0;
          cnt_d   = 2'd0;
          len_d   = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'd0;
`endif
        end else begin
          state_d = S_DONE;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
    in_ready_d = ready_of(state_d);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_LEN_HI;
      idx_q       <= 17'd0;
      cnt_q       <= 2'd0;
      len_q       <= 16'd0;
      word_q      <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      in_ready_q  <= 1'b1;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready         = in_ready_q;
  assign mem_write_enable = mem_we_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign cpu_hold         = cpu_hold_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface: receives a program as a byte stream and writes it word-by-word into instruction memory, which the CPU fetch path later reads by byte address.
- Holds the CPU in reset (cpu_hold) until the image is fully loaded.
- Sits between a byte source (UART receiver or testbench) and the write port of the instruction RAM.

Parameters:
ADDR_WIDTH, 8, word-address bits of instruction memory; capacity = 2**ADDR_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of first written word (CPU reset PC)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
start  input  1  single-cycle pulse; re-arms loader from DONE
mem_write_enable  output  1  one-cycle write strobe to instruction memory
mem_address  output  32  byte address of write (word aligned)
mem_write_data  output  32  instruction word
cpu_hold  output  1  1 = keep CPU (PC/register file) in reset
done  output  1  image loaded
error  output  1  sticky length/checksum error

Behaviour:
- Reset (async, reset_n low) sets:
  - state=LEN_HI; word index, byte counter, length all 0.
  - mem_write_enable=0, mem_address=0, mem_write_data=0.
  - cpu_hold=1, done=0, error=0.
  - in_ready decodes to 1 in LEN_HI.
- Byte transfer occurs on a rising edge with in_valid && in_ready; in_ready depends only on state, never on in_valid.
- in_ready=1 in LEN_HI, LEN_LO, DATA (and CHECK); 0 in WRITE, DONE, ERROR.
- Stream format: 16-bit word count N, big-endian (hi byte first), then N words of 4 bytes each, big-endian (first byte -> bits 31:24).
- States:
  - LEN_HI: accept -> len[15:8], go LEN_LO.
  - LEN_LO: accept -> len[7:0].
    - Full length == 0: go DONE.
    - Length > 2**ADDR_WIDTH: go ERROR.
    - Otherwise: go DATA.
  - DATA: shift byte into word register; after the 4th byte go WRITE; byte counter wraps 3->0.
  - WRITE: exactly one cycle.
    - mem_write_enable=1, mem_write_data=assembled word, mem_address=BASE_ADDR + 4*index (32-bit add, wraps modulo 2**32).
    - Outputs are registered: valid in the WRITE cycle itself.
    - Then index++; if index == N go DONE (or CHECK, see option), else DATA.
  - DONE: cpu_hold=0, done=1. start=1 -> LEN_HI with index, byte counter, length and checksum cleared; done drops next cycle and cpu_hold rises.
  - ERROR: cpu_hold=1, error=1, in_ready=0. Exit only by reset; start is ignored.
- start is ignored in every state except DONE.
- mem_write_enable is 0 in every state except WRITE. mem_address and mem_write_data hold their last values outside WRITE.
- Reset mid-load aborts immediately. Words already written stay in memory; the loader restarts at LEN_HI.
- Minimum cost per word is 5 cycles (4 byte accepts + WRITE). Gaps in in_valid only stall, never corrupt.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all accepted bytes, including both length bytes.
  - After the last WRITE, go CHECK (in_ready=1) and accept one checksum byte.
  - If it equals the running XOR, go DONE; else go ERROR.
  - For N=0, go CHECK instead of DONE after LEN_LO.
- Undefined: no CHECK state and no checksum register; the stream ends after the last word.

Test Plan:
- Load N=2 words 0x2008_0005, 0x2109_FFFF, in_valid held high -> writes addr 0x0 data 0x20080005, then addr 0x4 data 0x2109FFFF. Each mem_write_enable is exactly 1 cycle wide. done=1 and cpu_hold=0 on cycle 11 after the first accept (without checksum).
- Same stream with in_valid toggling every other cycle -> identical writes and data; only the timing stretches; no extra strobes.
- Length 0x0000 -> no writes; done=1 one cycle after the LEN_LO accept. Length 0x0101 with ADDR_WIDTH=8 -> error=1, in_ready=0, cpu_hold=1; a start pulse has no effect.
- Assert reset_n low during the 3rd byte of word 1 -> all outputs reach reset values asynchronously. A fresh N=1 load then writes addr 0x0 correctly.
- In DONE, pulse start, then load N=1 word 0xDEAD_BEEF -> cpu_hold rises the next cycle; write addr 0x0 data 0xDEADBEEF; done returns.
- With IMEM_LOADER_CHECKSUM_EN: N=1, word 0x01020304, checksum byte 0x05 (0x00^0x01^1^2^3^4) -> done=1. Checksum byte 0x06 -> error=1.
